// File: rtl/zap_wb_arbiter_pkg.sv
// Shared definitions for the zap Wishbone arbiter: FSM states, cycle-type
// tags and a one-hot to index helper.
package zap_wb_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic logic [31:0] onehot_to_index(input logic [31:0] onehot);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/zap_wb_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant to the first requester
// found searching upward from the slot after the last owner.
module zap_rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  requests,
    input  logic [PW-1:0] last,
    output logic [N-1:0]  grant
);

    logic [PW-1:0]  shamt;
    logic [2*N-1:0] doubled;
    logic [2*N-1:0] spread;
    logic [N-1:0]   rotated;
    logic [N-1:0]   lowest;

    // Rotate so the preferred slot sits at bit 0, isolate the lowest set bit,
    // then rotate the single bit back into requester order.
    always_comb begin
        shamt   = (last == PW'(N - 1)) ? '0 : last + PW'(1);
        doubled = {requests, requests} >> shamt;
        rotated = doubled[N-1:0];
        lowest  = rotated & (~rotated + N'(1));
        spread  = {lowest, lowest} << shamt;
        grant   = spread[2*N-1:N];
    end

endmodule

// File: rtl/zap_wb_arbiter.sv
// Round-robin Wishbone arbiter: grants one requester the downstream bus,
// holds it across bursts and aborts an owner that never gets acked.
module zap_wb_arbiter
    import zap_wb_arbiter_pkg::*;
#(
    parameter int          NUM_MST = 3,
    parameter int unsigned TIMEOUT = 32'd256
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [NUM_MST-1:0]    i_m_cyc,
    input  logic [NUM_MST-1:0]    i_m_stb,
    input  logic [NUM_MST-1:0]    i_m_we,
    input  logic [4*NUM_MST-1:0]  i_m_sel,
    input  logic [32*NUM_MST-1:0] i_m_adr,
    input  logic [32*NUM_MST-1:0] i_m_dat,
    input  logic [3*NUM_MST-1:0]  i_m_cti,
    output logic [NUM_MST-1:0]    o_m_ack,
    output logic [NUM_MST-1:0]    o_m_err,
    output logic [31:0]           o_m_dat,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [3:0]            o_wb_sel,
    output logic [31:0]           o_wb_adr,
    output logic [31:0]           o_wb_dat,
    output logic [2:0]            o_wb_cti,
    input  logic                  i_wb_ack,
    input  logic [31:0]           i_wb_dat,
    output logic [NUM_MST-1:0]    o_grant,
    output logic                  o_busy
);

    localparam int PW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RESET = PW'(NUM_MST - 1);

    arb_state_t         state;
    logic [NUM_MST-1:0] grant;
    logic [PW-1:0]      last_ptr;
    logic [CW-1:0]      cnt;

    logic [NUM_MST-1:0] pick;
    logic [PW-1:0]      pick_idx;

    logic        owner_cyc;
    logic        owner_stb;
    logic        owner_we;
    logic [3:0]  owner_sel;
    logic [31:0] owner_adr;
    logic [31:0] owner_dat;
    logic [2:0]  owner_cti;

    logic own;
    logic owner_live;
    logic owner_end;
    logic timeout_hit;
    logic release_bus;

    zap_rr_pick #(
        .N  (NUM_MST),
        .PW (PW)
    ) u_pick (
        .requests (i_m_cyc),
        .last     (last_ptr),
        .grant    (pick)
    );

    assign pick_idx = PW'(onehot_to_index(32'(pick)));

    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        owner_we  = 1'b0;
        owner_sel = '0;
        owner_adr = '0;
        owner_dat = '0;
        owner_cti = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (grant[k]) begin
                owner_cyc = i_m_cyc[k];
                owner_stb = i_m_stb[k];
                owner_we  = i_m_we[k];
                owner_sel = i_m_sel[4*k +: 4];
                owner_adr = i_m_adr[32*k +: 32];
                owner_dat = i_m_dat[32*k +: 32];
                owner_cti = i_m_cti[3*k +: 3];
            end
        end
    end

    // An ack wins over a timeout landing in the same cycle.
    assign own         = (state == OWN);
    assign owner_live  = own & owner_cyc;
    assign owner_end   = (owner_cti == CTI_CLASSIC) || (owner_cti == CTI_EOB);
    assign timeout_hit = owner_live & owner_stb & ~i_wb_ack & (cnt == CNT_LAST);
    assign release_bus = own & (~owner_cyc | (i_wb_ack & owner_stb & owner_end) | timeout_hit);

    assign o_wb_cyc = owner_live & ~timeout_hit;
    assign o_wb_stb = owner_live & owner_stb & ~timeout_hit;
    assign o_wb_we  = owner_live & owner_we;
    assign o_wb_sel = owner_live ? owner_sel : '0;
    assign o_wb_adr = owner_live ? owner_adr : '0;
    assign o_wb_dat = owner_live ? owner_dat : '0;
    assign o_wb_cti = owner_live ? owner_cti : '0;

    assign o_m_ack = (owner_live & i_wb_ack) ? grant : '0;
    assign o_m_err = timeout_hit ? grant : '0;
    assign o_m_dat = i_wb_dat;
    assign o_grant = grant;
    assign o_busy  = own;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            last_ptr <= PTR_RESET;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|i_m_cyc) begin
                        state    <= OWN;
                        grant    <= pick;
                        last_ptr <= pick_idx;
                    end
                end
                OWN: begin
                    if (release_bus) begin
                        state <= IDLE;
                        grant <= '0;
                        cnt   <= '0;
                    end else if (i_wb_ack) begin
                        cnt <= '0;
                    end else if (owner_stb) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Self-checking bench for zap_wb_arbiter: a cycle model of the arbitration
// rules checked every cycle, plus directed literal expectations.
module tb_zap_wb_arbiter;

    localparam int N  = 3;
    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_cyc;
    logic [2:0]  m_stb;
    logic [2:0]  m_we;
    logic [11:0] m_sel;
    logic [95:0] m_adr;
    logic [95:0] m_dat;
    logic [8:0]  m_cti;
    logic        wb_ack;
    logic [31:0] wb_dat;

    logic [2:0]  o_m_ack;
    logic [2:0]  o_m_err;
    logic [31:0] o_m_dat;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [2:0]  o_wb_cti;
    logic [2:0]  o_grant;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    zap_wb_arbiter #(
        .NUM_MST (N),
        .TIMEOUT (32'd256)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_m_cyc   (m_cyc),
        .i_m_stb   (m_stb),
        .i_m_we    (m_we),
        .i_m_sel   (m_sel),
        .i_m_adr   (m_adr),
        .i_m_dat   (m_dat),
        .i_m_cti   (m_cti),
        .o_m_ack   (o_m_ack),
        .o_m_err   (o_m_err),
        .o_m_dat   (o_m_dat),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_sel  (o_wb_sel),
        .o_wb_adr  (o_wb_adr),
        .o_wb_dat  (o_wb_dat),
        .o_wb_cti  (o_wb_cti),
        .i_wb_ack  (wb_ack),
        .i_wb_dat  (wb_dat),
        .o_grant   (o_grant),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wb_dat = wb_dat + 32'h0000_0111;
    endtask

    task automatic drive_master(input int k, input logic cyc, input logic stb, input logic we,
                                input logic [2:0] cti, input logic [31:0] adr);
        m_cyc[k]           = cyc;
        m_stb[k]           = stb;
        m_we[k]            = we;
        m_cti[3*k +: 3]    = cti;
        m_adr[32*k +: 32]  = adr;
        m_dat[32*k +: 32]  = ~adr;
        m_sel[4*k +: 4]    = 4'hF >> k;
    endtask

    // Model: who owns the bus (-1 when idle), who owned it last, and how many
    // strobed cycles the owner has waited since its last ack.
    int          mdl_owner = -1;
    int          mdl_last  = N - 1;
    int          mdl_wait  = 0;
    logic        own, live, stb_on, to_hit, fin, found;
    logic [2:0]  ex_grant, ex_ack, ex_err, ex_cti;
    logic        ex_cyc, ex_stb, ex_we;
    logic [3:0]  ex_sel;
    logic [31:0] ex_adr, ex_dat;

    always @(negedge rst_n) begin
        mdl_owner = -1;
        mdl_last  = N - 1;
        mdl_wait  = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_owner = -1;
            mdl_last  = N - 1;
            mdl_wait  = 0;
        end
        own    = (mdl_owner >= 0) && rst_n;
        live   = 1'b0;
        stb_on = 1'b0;
        ex_cti = 3'b000;
        if (own) begin
            live   = m_cyc[mdl_owner];
            stb_on = live && m_stb[mdl_owner];
            ex_cti = m_cti[3*mdl_owner +: 3];
        end
        to_hit   = stb_on && !wb_ack && (mdl_wait == TO - 1);
        ex_grant = own ? 3'(1 << mdl_owner) : 3'b000;
        ex_cyc   = live && !to_hit;
        ex_stb   = stb_on && !to_hit;
        ex_we    = live ? m_we[mdl_owner] : 1'b0;
        ex_sel   = live ? m_sel[4*mdl_owner +: 4] : 4'h0;
        ex_adr   = live ? m_adr[32*mdl_owner +: 32] : 32'h0;
        ex_dat   = live ? m_dat[32*mdl_owner +: 32] : 32'h0;
        ex_ack   = (live && wb_ack) ? ex_grant : 3'b000;
        ex_err   = to_hit ? ex_grant : 3'b000;

        check_output("cmp_grant",  32'(o_grant),  32'(ex_grant));
        check_output("cmp_busy",   32'(o_busy),   32'(own));
        check_output("cmp_wb_cyc", 32'(o_wb_cyc), 32'(ex_cyc));
        check_output("cmp_wb_stb", 32'(o_wb_stb), 32'(ex_stb));
        check_output("cmp_wb_we",  32'(o_wb_we),  32'(ex_we));
        check_output("cmp_wb_sel", 32'(o_wb_sel), 32'(ex_sel));
        check_output("cmp_wb_adr", o_wb_adr,      ex_adr);
        check_output("cmp_wb_dat", o_wb_dat,      ex_dat);
        check_output("cmp_wb_cti", 32'(o_wb_cti), 32'(live ? ex_cti : 3'b000));
        check_output("cmp_m_ack",  32'(o_m_ack),  32'(ex_ack));
        check_output("cmp_m_err",  32'(o_m_err),  32'(ex_err));
        check_output("cmp_m_dat",  o_m_dat,       wb_dat);

        if (rst_n) begin
            if (!own) begin
                mdl_wait = 0;
                found    = 1'b0;
                for (int d = 1; d <= N; d++) begin
                    if (!found && m_cyc[(mdl_last + d) % N]) begin
                        found     = 1'b1;
                        mdl_owner = (mdl_last + d) % N;
                        mdl_last  = mdl_owner;
                    end
                end
            end else begin
                fin = !live || (wb_ack && stb_on && (ex_cti == 3'b000 || ex_cti == 3'b111)) || to_hit;
                if (fin) begin
                    mdl_owner = -1;
                    mdl_wait  = 0;
                end else if (wb_ack) begin
                    mdl_wait = 0;
                end else if (stb_on) begin
                    mdl_wait = mdl_wait + 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        m_cyc  = '0;
        m_stb  = '0;
        m_we   = '0;
        m_sel  = '0;
        m_adr  = '0;
        m_dat  = '0;
        m_cti  = '0;
        wb_ack = 1'b0;
        wb_dat = 32'hD000_0000;
        repeat (3) tick();
        check_output("reset_grant",  32'(o_grant),  32'h0);
        check_output("reset_wb_cyc", 32'(o_wb_cyc), 32'h0);
        rst_n = 1'b1;

        // Code and data request together; code wins, then data after one gap.
        drive_master(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0100);
        drive_master(1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0200);
        tick();
        check_output("t1_first_grant", 32'(o_grant), 32'h1);
        check_output("t1_adr",         o_wb_adr,      32'h0000_0100);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        drive_master(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        check_output("t1_gap_grant", 32'(o_grant), 32'h0);
        tick();
        check_output("t1_second_grant", 32'(o_grant), 32'h2);
        check_output("t1_second_adr",   o_wb_adr,      32'h0000_0200);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        drive_master(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tick();

        // Data 16-beat burst while code waits.
        drive_master(1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300);
        tick();
        check_output("t2_burst_grant", 32'(o_grant), 32'h2);
        drive_master(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0400);
        for (int b = 0; b < 16; b++) begin
            drive_master(1, 1'b1, 1'b1, 1'b0, (b == 15) ? 3'b111 : 3'b010, 32'h0000_0300 + 32'(4 * b));
            wb_ack = 1'b1;
            #1;
            check_output("t2_burst_hold", 32'(o_grant), 32'h2);
            tick();
        end
        wb_ack = 1'b0;
        drive_master(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        check_output("t2_gap", 32'(o_grant), 32'h0);
        tick();
        check_output("t2_code_after_burst", 32'(o_grant), 32'h1);

        // Code owner never acked: error pulse, then data is granted.
        drive_master(1, 1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_0500);
        repeat (TO - 1) tick();
        check_output("t3_err_pulse",  32'(o_m_err),  32'h1);
        check_output("t3_err_cyc",    32'(o_wb_cyc), 32'h0);
        tick();
        check_output("t3_err_single", 32'(o_m_err),  32'h0);
        check_output("t3_idle_grant", 32'(o_grant),  32'h0);
        tick();
        check_output("t3_next_owner", 32'(o_grant),  32'h2);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        for (int k = 0; k < N; k++) drive_master(k, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tick();
        tick();

        // Reset in the middle of a DMA burst.
        drive_master(2, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0600);
        tick();
        check_output("t4_burst_grant", 32'(o_grant), 32'h4);
        for (int b = 1; b <= 4; b++) begin
            wb_ack = 1'b1;
            drive_master(2, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0600 + 32'(4 * b));
            tick();
        end
        wb_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t4_reset_cyc",   32'(o_wb_cyc), 32'h0);
        check_output("t4_reset_ack",   32'(o_m_ack),  32'h0);
        check_output("t4_reset_grant", 32'(o_grant),  32'h0);
        drive_master(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0700);
        tick();
        rst_n  = 1'b1;
        wb_ack = 1'b0;
        tick();
        check_output("t4_first_after_reset", 32'(o_grant), 32'h1);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        for (int k = 0; k < N; k++) drive_master(k, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tick();
        tick();

        // Owner abandons a burst at beat 3, then a stray ack arrives in IDLE.
        drive_master(1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0800);
        tick();
        check_output("t5_grant", 32'(o_grant), 32'h2);
        for (int b = 1; b <= 2; b++) begin
            wb_ack = 1'b1;
            drive_master(1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0800 + 32'(4 * b));
            tick();
        end
        wb_ack = 1'b0;
        drive_master(1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0000_0808);
        #1;
        check_output("t5_drop_same_cycle", 32'(o_wb_cyc), 32'h0);
        tick();
        check_output("t5_idle_busy", 32'(o_busy), 32'h0);
        wb_ack = 1'b1;
        #1;
        check_output("t5_stray_ack", 32'(o_m_ack), 32'h0);
        tick();
        wb_ack = 1'b0;
        tick();

        // All three requesting single classic reads: fair rotation from 0.
        rst_n = 1'b0;
        drive_master(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0900);
        drive_master(1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0A00);
        drive_master(2, 1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_0B00);
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_output("t6_rr_seq", 32'(o_grant), 32'(1 << (i % 3)));
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
            tick();
        end
        for (int k = 0; k < N; k++) drive_master(k, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_wb_arbiter.md
ZAP_WB_ARBITER -- requirements
Module: zap_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MST, default 3, number of Wishbone requesters (index 0 = code cache, 1 = data cache, 2 = debug/DMA).
REQ-002 SHALL have parameter TIMEOUT, default 32'd256, cycles without ack before bus abort.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_m_cyc, i_m_stb, i_m_we  in  NUM_MST each  per-requester Wishbone controls.
REQ-006 SHALL have ports i_m_sel  in  4*NUM_MST; i_m_adr, i_m_dat  in  32*NUM_MST; i_m_cti  in  3*NUM_MST  packed per-requester fields, requester k at slice k.
REQ-007 SHALL have ports o_m_ack, o_m_err  out  NUM_MST  per-requester responses; o_m_dat  out  32  read data broadcast to all requesters.
REQ-008 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we  out  1; o_wb_sel  out  4; o_wb_adr, o_wb_dat  out  32; o_wb_cti  out  3  downstream bus.
REQ-009 SHALL have ports i_wb_ack  in  1; i_wb_dat  in  32  downstream response.
REQ-010 SHALL have ports o_grant  out  NUM_MST  one-hot current owner; o_busy  out  1  high in OWN state.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, OWN.
REQ-012 In IDLE, when any i_m_cyc bit is high, SHALL select the owner round-robin: the first requester with cyc high, searching upward from (last owner + 1) mod NUM_MST; SHALL register o_grant and enter OWN on the next edge (one-cycle grant latency).
REQ-013 In IDLE, o_wb_cyc, o_wb_stb, o_m_ack and o_m_err SHALL be 0.
REQ-014 In OWN, o_wb_cyc/stb/we/sel/adr/dat/cti SHALL combinationally reflect the owner slice, gated by the owner's i_m_cyc.
REQ-015 In OWN, o_m_ack[owner] SHALL equal i_wb_ack; non-owner ack/err SHALL be 0; o_m_dat SHALL equal i_wb_dat at all times.
REQ-016 Release SHALL occur on owner ack with owner stb high and owner cti in {3'b000, 3'b111}, returning to IDLE on that edge.
REQ-017 Release SHALL occur when the owner deasserts i_m_cyc (mid-burst included); o_wb_cyc SHALL drop in the same cycle.
REQ-018 Bursts with cti 3'b010 SHALL hold the grant across all beats; no other requester SHALL be granted until release.
REQ-019 After every release the FSM SHALL spend at least one cycle in IDLE (one-cycle bus gap).
REQ-020 A timeout counter, width $clog2(TIMEOUT+1), SHALL increment each OWN cycle with owner stb high and i_wb_ack low, and clear on ack or in IDLE.
REQ-021 When the counter reaches TIMEOUT-1 without ack, SHALL pulse o_m_err[owner] for one cycle, force o_wb_cyc/stb to 0 in that cycle, and return to IDLE.
REQ-022 Ack and timeout in the same cycle: ack SHALL win; no error is raised.
REQ-023 An i_wb_ack arriving in IDLE SHALL be ignored and not forwarded.
REQ-024 The last-owner pointer SHALL update only on entry to OWN.

Reset
REQ-025 On i_reset_n low, SHALL asynchronously force state IDLE, o_grant 0, counter 0, last-owner pointer NUM_MST-1 (requester 0 wins first).
REQ-026 Reset mid-burst SHALL drop o_wb_cyc/stb and all acks/errs immediately, without waiting for the clock.
REQ-027 All outputs SHALL be 0 during reset, except o_m_dat, which follows i_wb_dat.

Structure
REQ-028 SHALL place the FSM state enum and CTI constants (CTI_CLASSIC 3'b000, CTI_INCR 3'b010, CTI_EOB 3'b111) in the shared zap package.
REQ-029 SHALL instantiate one sub-module, zap_rr_pick, a combinational round-robin one-hot selector (requests, last pointer -> one-hot grant).

Verification
REQ-030 Code and data cyc rise together after reset -> o_grant=3'b001 one cycle later; code single classic read acked -> one IDLE cycle -> o_grant=3'b010.
REQ-031 Data 16-beat burst (cti 010 x15, 111 last) while code requests -> grant held 16 acks; code granted 2 cycles after the last ack.
REQ-032 Owner stb high, no ack for 256 cycles -> o_m_err[owner]=1 for exactly one cycle, o_wb_cyc=0, grant moves to the next requester.
REQ-033 Reset asserted at beat 5 of a burst -> o_wb_cyc=0 before the next edge; after release, requester 0 is granted first.
REQ-034 Owner drops cyc mid-burst at beat 3 -> o_wb_cyc=0 same cycle; stray i_wb_ack in IDLE -> all o_m_ack=0.
REQ-035 All three requesters continuously requesting single classic reads -> grant sequence 0,1,2,0,1,2 with no starvation.
